// File: rtl/alu_pkg.sv
// Shared definitions for the four-function ALU: operation encoding and default width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: b is inverted and sub drives the carry-in, so SUB is a + ~b + 1.
module alu_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = full[WIDTH-1:0];
        cout  = full[WIDTH];
        // Overflow when both effective operands share a sign that the sum does not.
        ovf   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ full[WIDTH-1]);
    end

endmodule

// File: rtl/alu_4f_32.sv
// Four-function ALU (ADD/SUB/AND/OR) with N/Z/C/V flags; result and flags registered together.
module alu_4f_32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    alu_op_t          op;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] res_d;
    logic             n_d;
    logic             z_d;
    logic             c_d;
    logic             v_d;

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (a),
        .b    (b),
        .sub  (control[0]),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always_comb begin
        op    = alu_op_t'(control);
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        unique case (op)
            ALU_ADD, ALU_SUB: begin
                res_d = sum;
                c_d   = cout;
                v_d   = ovf;
            end
            ALU_AND: res_d = a & b;
            ALU_OR:  res_d = a | b;
            default: res_d = '0;
        endcase
        n_d = res_d[WIDTH-1];
        z_d = (res_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            n      <= 1'b0;
            z      <= 1'b0;
            c      <= 1'b0;
            v      <= 1'b0;
        end else begin
            result <= res_d;
            n      <= n_d;
            z      <= z_d;
            c      <= c_d;
            v      <= v_d;
        end
    end

endmodule

// File: tb/tb_alu_4f_32.sv
// Scoreboard bench for alu_4f_32: driver queues expectations from an arithmetic model, monitor compares.
module tb_alu_4f_32;

    typedef struct packed {
        logic [31:0] r;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  control = '0;
    logic [31:0] result;
    logic        n, z, c, v;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    alu_4f_32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .control (control),
        .result  (result),
        .n       (n),
        .z       (z),
        .c       (c),
        .v       (v)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
        exp_t        e;
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      ss;
        e = '0;
        case (op)
            2'd0: begin
                e.r = x + y;
                e.c = (ux + uy) > 64'd4294967295;
                ss  = sx + sy;
                e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'd1: begin
                e.r = x - y;
                e.c = (ux >= uy);
                ss  = sx - sy;
                e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'd2: e.r = x & y;
            default: e.r = x | y;
        endcase
        e.n = e.r[31];
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] op);
        @(negedge clk);
        a       = ia;
        b       = ib;
        control = op;
        q.push_back(model(ia, ib, op));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({result, n, z, c, v} !== 36'd0) begin
            errors++;
            $display("FAIL %s: result=%h nzcv=%b%b%b%b, required all 0", name, result, n, z, c, v);
        end
    endtask

    // Monitor: every rising edge presents the previous cycle's operation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({result, n, z, c, v} !== e) begin
                    errors++;
                    $display("FAIL op: result=%h nzcv=%b%b%b%b, required result=%h nzcv=%b%b%b%b",
                             result, n, z, c, v, e.r, e.n, e.z, e.c, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] specials [6];
        logic [31:0] ra, rb;
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'hFFFF_FFFF;
        specials[5] = 32'hFFFF_FFFE;

        #3;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        check_zero("reset_held_over_edge");
        @(negedge clk);
        reset = 1'b0;

        issue(32'd687, 32'd458125, 2'd0);
        issue(32'd548, 32'd548, 2'd1);
        issue(32'hFFFF_FFFF, 32'd1, 2'd0);
        issue(32'h7FFF_FFFF, 32'd501, 2'd0);
        issue(32'hFFFF_FFFE, 32'h7FFF_FFFF, 2'd1);
        issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'd2);
        issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'd3);
        issue(32'd0, 32'd1, 2'd1);
        issue(32'h8000_0000, 32'h8000_0000, 2'd0);
        issue(32'h8000_0000, 32'd1, 2'd1);
        issue(32'd0, 32'd0, 2'd2);
        issue(32'd0, 32'd0, 2'd3);
        drain();

        // Asynchronous reset mid-run with nonzero outputs present.
        issue(32'd687, 32'd458125, 2'd0);
        drain();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset_immediate");
        @(posedge clk);
        #1;
        check_zero("async_reset_held");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            ra = (($urandom_range(0, 3)) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb = (($urandom_range(0, 3)) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            issue(ra, rb, 2'($urandom_range(0, 3)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
